core_sequencer: RTL and testbench

//  Multi-cycle control FSM for the core: owns the single shared 32-bit memory port,

---
 rtl/core_sequencer_pkg.sv | 25 ++
 rtl/core_sequencer_watchdog.sv | 30 +++
 rtl/core_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_core_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_sequencer_pkg.sv
// Shared types and widths for the core sequencer and its watchdog.
package core_sequencer_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned HALF_W = 16;

  // Sequencer states: fetch request/wait, execute, memory request/wait, terminal states
  typedef enum logic [2:0] {
    F_REQ,
    F_WAIT,
    EXEC,
    M_REQ,
    M_WAIT,
    HALT,
    FAULT
  } seq_state_t;

  // Kind of transaction currently owning the memory port
  typedef enum logic [1:0] {
    MEM_FETCH,
    MEM_LOAD,
    MEM_STORE
  } mem_op_t;

endpackage

// File: rtl/core_sequencer_watchdog.sv
// Bus-response watchdog: counts wait cycles since grant, flags the last allowed cycle.
module seq_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q;

  // Wait-cycle counter, cleared at grant and advanced on every waiting cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // High in the final wait cycle; a response in this same cycle still wins
  assign expired_c = en && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle core control: owns the shared memory port, holds the instruction,
// and emits one-cycle commit strobes.
module core_sequencer
  import core_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ip,
  input  logic              is_load,
  input  logic              is_store,
  input  logic              is_halt,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [HALF_W-1:0] dm_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr_q,
  output logic              commit,
  output logic [HALF_W-1:0] ld_data,
  output logic [DATA_W-1:0] retired_cnt,
  output logic              halted,
  output logic              fault
);

  seq_state_t        state_q, state_d;
  mem_op_t           op_q, op_d;
  logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
  logic              mem_req_d, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic [DATA_W-1:0] instr_d;
  logic              commit_d;
  logic [HALF_W-1:0] ld_data_d;
  logic [DATA_W-1:0] retired_d;
  logic              halted_d, fault_d;
  logic              wd_clr, wd_en, wd_expired;

  seq_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .clr       (wd_clr),
    .en        (wd_en),
    .expired_c (wd_expired)
  );

  // Fetch address follows ip directly: ip only settles after the commit edge,
  // which is also the cycle the fetch request is being set up.
  assign mem_addr = (op_q == MEM_FETCH) ? ip : dm_addr_q;

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    dm_addr_d   = dm_addr_q;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_wdata_d = mem_wdata;
    instr_d     = instr_q;
    commit_d    = 1'b0;
    ld_data_d   = ld_data;
    retired_d   = retired_cnt;
    halted_d    = halted;
    fault_d     = fault;
    wd_clr      = 1'b0;
    wd_en       = 1'b0;

    case (state_q)
      F_REQ: begin
        if (!mem_req) begin
          op_d      = MEM_FETCH;
          mem_req_d = 1'b1;
          mem_we_d  = 1'b0;
        end else if (mem_gnt) begin
          mem_req_d = 1'b0;
          wd_clr    = 1'b1;
          state_d   = F_WAIT;
        end
      end

      F_WAIT: begin
        wd_en = 1'b1;
        if (mem_rvalid) begin
          instr_d = mem_rdata;
          state_d = EXEC;
        end else if (wd_expired) begin
          fault_d = 1'b1;
          state_d = FAULT;
        end
      end

      EXEC: begin
        if (is_halt) begin
          commit_d  = 1'b1;
          retired_d = retired_cnt + DATA_W'(1);
          halted_d  = 1'b1;
          state_d   = HALT;
        end else if (is_load || is_store) begin
          state_d = M_REQ;
        end else begin
          commit_d  = 1'b1;
          retired_d = retired_cnt + DATA_W'(1);
          state_d   = F_REQ;
        end
      end

      M_REQ: begin
        if (!mem_req) begin
          op_d        = is_load ? MEM_LOAD : MEM_STORE;
          mem_req_d   = 1'b1;
          mem_we_d    = !is_load;
          dm_addr_d   = dm_addr;
          mem_wdata_d = {16'h0000, dm_wdata};
        end else if (mem_gnt) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          wd_clr    = 1'b1;
          state_d   = M_WAIT;
        end
      end

      M_WAIT: begin
        wd_en = 1'b1;
        if (mem_rvalid) begin
          if (op_q == MEM_LOAD) begin
            ld_data_d = mem_rdata[HALF_W-1:0];
          end
          commit_d  = 1'b1;
          retired_d = retired_cnt + DATA_W'(1);
          state_d   = F_REQ;
        end else if (wd_expired) begin
          fault_d = 1'b1;
          state_d = FAULT;
        end
      end

      HALT, FAULT: begin
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end

      default: begin
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
        state_d   = F_REQ;
      end
    endcase
  end

  // State and registered outputs; reset overrides everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= F_REQ;
      op_q        <= MEM_FETCH;
      dm_addr_q   <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
      instr_q     <= '0;
      commit      <= 1'b0;
      ld_data     <= '0;
      retired_cnt <= '0;
      halted      <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      dm_addr_q   <= dm_addr_d;
      mem_req     <= mem_req_d;
      mem_we      <= mem_we_d;
      mem_wdata   <= mem_wdata_d;
      instr_q     <= instr_d;
      commit      <= commit_d;
      ld_data     <= ld_data_d;
      retired_cnt <= retired_d;
      halted      <= halted_d;
      fault       <= fault_d;
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: fetch, load, store, timeout, halt, mid-transaction reset.
module tb_core_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ip;
  logic        is_load, is_store, is_halt;
  logic [31:0] dm_addr;
  logic [15:0] dm_wdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] instr_q;
  logic        commit;
  logic [15:0] ld_data;
  logic [31:0] retired_cnt;
  logic        halted, fault;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Decoder stand-in: top nibble 1 = load, 2 = store, F = halt, else ALU
  assign is_load  = (instr_q[31:28] == 4'h1);
  assign is_store = (instr_q[31:28] == 4'h2);
  assign is_halt  = (instr_q[31:28] == 4'hF);

  core_sequencer #(
    .ADDR_W  (32),
    .TIMEOUT (64)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ip          (ip),
    .is_load     (is_load),
    .is_store    (is_store),
    .is_halt     (is_halt),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .instr_q     (instr_q),
    .commit      (commit),
    .ld_data     (ld_data),
    .retired_cnt (retired_cnt),
    .halted      (halted),
    .fault       (fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a request to appear
  task automatic wait_req(input string tag, input int max_cycles);
    int n = 0;
    while (!mem_req && n < max_cycles) begin
      step();
      n++;
    end
    check({tag, "_req_seen"}, 32'(mem_req), 32'd1);
  endtask

  // Serve one fetch with single-cycle grant and response; ends in the EXEC cycle
  task automatic serve_fetch(input string tag, input logic [31:0] instr);
    wait_req(tag, 4);
    check({tag, "_fetch_addr"}, mem_addr, ip);
    check({tag, "_fetch_we"}, 32'(mem_we), 32'd0);
    mem_gnt = 1'b1;
    step();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = instr;
    step();
    mem_rvalid = 1'b0;
    check({tag, "_instr_q"}, instr_q, instr);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int reqs, commits;
    reset = 1'b1; ip = 32'd1; dm_addr = '0; dm_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    step(); step();

    // Reset state
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_instr_q", instr_q, 32'd0);
    check("rst_commit", 32'(commit), 32'd0);
    check("rst_ld_data", 32'(ld_data), 32'd0);
    check("rst_retired", retired_cnt, 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);

    // 1: ALU instruction, commit in the fourth cycle after the request
    reset = 1'b0;
    step();
    check("t1_c1_req", 32'(mem_req), 32'd1);
    check("t1_c1_addr", mem_addr, 32'd1);
    mem_gnt = 1'b1;
    step();
    check("t1_c2_req", 32'(mem_req), 32'd0);
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013;
    step();
    mem_rvalid = 1'b0;
    check("t1_c3_instr", instr_q, 32'h0000_0013);
    check("t1_c3_commit", 32'(commit), 32'd0);
    step();
    check("t1_c4_commit", 32'(commit), 32'd1);
    check("t1_c4_retired", retired_cnt, 32'd1);
    ip = 32'd2;
    step();
    check("t1_c5_commit", 32'(commit), 32'd0);
    check("t1_next_req", 32'(mem_req), 32'd1);
    check("t1_next_addr", mem_addr, 32'd2);

    // 2: load from 0x40, low half of the response lands in ld_data with commit
    dm_addr = 32'h0000_0040;
    serve_fetch("t2", 32'h1000_0000);
    step();
    check("t2_setup_req", 32'(mem_req), 32'd0);
    step();
    check("t2_req", 32'(mem_req), 32'd1);
    check("t2_we", 32'(mem_we), 32'd0);
    check("t2_addr", mem_addr, 32'h0000_0040);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hABCD_1234;
    step();
    mem_rvalid = 1'b0;
    check("t2_commit", 32'(commit), 32'd1);
    check("t2_ld_data", 32'(ld_data), 32'h0000_1234);
    check("t2_retired", retired_cnt, 32'd2);
    ip = 32'd3;

    // 3: store with grant withheld for three cycles
    dm_addr = 32'h0000_0080; dm_wdata = 16'hBEEF;
    serve_fetch("t3", 32'h2000_0000);
    step();
    step();
    check("t3_req", 32'(mem_req), 32'd1);
    check("t3_we", 32'(mem_we), 32'd1);
    check("t3_addr", mem_addr, 32'h0000_0080);
    check("t3_wdata", mem_wdata, 32'h0000_BEEF);
    commits = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3_hold_req", 32'(mem_req), 32'd1);
      check("t3_hold_we", 32'(mem_we), 32'd1);
      check("t3_hold_addr", mem_addr, 32'h0000_0080);
      check("t3_hold_wdata", mem_wdata, 32'h0000_BEEF);
      if (commit) commits++;
    end
    check("t3_no_early_commit", 32'(commits), 32'd0);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    check("t3_req_dropped", 32'(mem_req), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0000;
    step();
    mem_rvalid = 1'b0;
    check("t3_commit", 32'(commit), 32'd1);
    check("t3_retired", retired_cnt, 32'd3);
    check("t3_ld_data_kept", 32'(ld_data), 32'h0000_1234);
    ip = 32'd4;
    step();
    check("t3_single_commit", 32'(commit), 32'd0);

    // Response in the last allowed wait cycle still succeeds
    wait_req("tb", 4);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    for (int i = 0; i < 63; i++) step();
    check("tb_no_fault_yet", 32'(fault), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0033;
    step();
    mem_rvalid = 1'b0;
    check("tb_edge_instr", instr_q, 32'h0000_0033);
    check("tb_edge_fault", 32'(fault), 32'd0);
    step();
    check("tb_edge_commit", 32'(commit), 32'd1);
    ip = 32'd5;

    // 4: no response at all -> fault after 64 wait cycles
    wait_req("t4", 4);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    commits = 0;
    for (int i = 0; i < 63; i++) begin
      step();
      if (commit) commits++;
    end
    check("t4_fault_before_limit", 32'(fault), 32'd0);
    step();
    check("t4_fault", 32'(fault), 32'd1);
    check("t4_req_low", 32'(mem_req), 32'd0);
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      mem_gnt = 1'b1; mem_rvalid = 1'b1;
      step();
      if (commit) commits++;
      if (mem_req) reqs++;
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    check("t4_no_commit", 32'(commits), 32'd0);
    check("t4_no_req", 32'(reqs), 32'd0);
    check("t4_fault_sticky", 32'(fault), 32'd1);
    ip = 32'h0000_0010;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t4_rst_fault", 32'(fault), 32'd0);
    check("t4_rst_retired", retired_cnt, 32'd0);
    step();
    check("t4_refetch_req", 32'(mem_req), 32'd1);
    check("t4_refetch_addr", mem_addr, 32'h0000_0010);

    // 5: halt retires once, then the port stays idle
    serve_fetch("t5", 32'hF000_0000);
    step();
    check("t5_commit", 32'(commit), 32'd1);
    check("t5_halted", 32'(halted), 32'd1);
    check("t5_retired", retired_cnt, 32'd1);
    reqs = 0; commits = 0;
    for (int i = 0; i < 100; i++) begin
      mem_gnt    = i[0];
      mem_rvalid = !i[0];
      mem_rdata  = 32'h5555_AAAA;
      step();
      if (mem_req) reqs++;
      if (commit) commits++;
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    check("t5_no_req", 32'(reqs), 32'd0);
    check("t5_no_commit", 32'(commits), 32'd0);
    check("t5_halted_sticky", 32'(halted), 32'd1);
    check("t5_instr_kept", instr_q, 32'hF000_0000);

    // 6: reset during fetch wait, late response dropped
    reset = 1'b1;
    step();
    reset = 1'b0;
    ip = 32'h0000_0200;
    wait_req("t6", 4);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    mem_rvalid = 1'b0;
    check("t6_instr_q", instr_q, 32'd0);
    check("t6_halted", 32'(halted), 32'd0);
    check("t6_refetch_req", 32'(mem_req), 32'd1);
    check("t6_refetch_addr", mem_addr, 32'h0000_0200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
